seq_mult_pipe: RTL and testbench

- Parametrised iterative shift-add multiplier; successor to the team's fixed-width, unsigned, one-bit-per-cycle multiplier.
- Adds:
  - per-operation signed/unsigned mode;
  - configurable radix: BITS_PER_CYCLE multiplier bits consumed per cycle;
  - valid/ready handshakes on both the input and the output, so a held result supports backpressure;
  - synchronous abort.
- Sits between datapath operand registers and a result consumer in arithmetic units where area matters more than latency.

---
 rtl/seq_mult_pipe_pkg.sv | 19 +
 rtl/seq_mult_pipe_if.sv | 27 ++
 rtl/seq_mult_pipe_pp_step.sv | 17 +
 rtl/seq_mult_pipe.sv | 121 ++++++++++++
 tb/tb_seq_mult_pipe.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_mult_pipe_pkg.sv
// Shared types and elaboration helpers for the iterative shift-add multiplier.
package seq_mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int unsigned calc_steps(input int unsigned width, input int unsigned bpc);
    return width / bpc;
  endfunction

  // Radix limited to 1/2/4 bits so the partial-product multiplier stays tiny.
  function automatic bit cfg_legal(input int unsigned width, input int unsigned bpc);
    return (width >= 2) && ((bpc == 1) || (bpc == 2) || (bpc == 4)) && ((width % bpc) == 0);
  endfunction

endpackage

// File: rtl/seq_mult_pipe_if.sv
// Operand/result handshake bundle between the operand source and the multiplier.
interface seq_mult_pipe_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic                 in_valid;
  logic                 in_ready;
  logic                 is_signed;
  logic [WIDTH-1:0]     op_a;
  logic [WIDTH-1:0]     op_b;
  logic                 abort;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output in_valid, is_signed, op_a, op_b, abort, out_ready,
    input  in_ready, out_valid, product, busy
  );

  modport slave (
    input  in_valid, is_signed, op_a, op_b, abort, out_ready,
    output in_ready, out_valid, product, busy
  );

endinterface

// File: rtl/seq_mult_pipe_pp_step.sv
// One radix digit of the shift-add multiply: (mag_a * digit) << shift, full product width.
module mult_pp_step #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1,
  parameter int unsigned SHW            = 4
) (
  input  logic [WIDTH-1:0]          i_mag_a,
  input  logic [BITS_PER_CYCLE-1:0] i_digit,
  input  logic [SHW-1:0]            i_shift,
  output logic [2*WIDTH-1:0]        o_pp
);

  localparam int unsigned PW = 2 * WIDTH;

  assign o_pp = (PW'(i_mag_a) * PW'(i_digit)) << i_shift;

endmodule

// File: rtl/seq_mult_pipe.sv
// Iterative signed/unsigned shift-add multiplier retiring BITS_PER_CYCLE multiplier bits per cycle,
// with valid/ready on both sides and a synchronous abort.
module seq_mult_pipe
  import seq_mult_pkg::*;
#(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  seq_mult_pipe_if.slave   bus
);

  localparam int unsigned STEPS = calc_steps(WIDTH, BITS_PER_CYCLE);
  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam int unsigned SHW   = $clog2(PW);

  if (!cfg_legal(WIDTH, BITS_PER_CYCLE)) begin : g_bad_cfg
    $error("seq_mult_pipe: illegal WIDTH/BITS_PER_CYCLE combination");
  end

  state_e            r_state;
  state_e            w_next;
  logic [WIDTH-1:0]  r_mag_a;
  logic [WIDTH-1:0]  r_mag_b;
  logic [PW-1:0]     r_acc;
  logic [PW-1:0]     r_product;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_sign;
  logic              r_out_valid;
  logic              r_busy;

  logic              w_accept;
  logic              w_step_en;
  logic              w_last;
  logic [WIDTH-1:0]  w_mag_a_in;
  logic [WIDTH-1:0]  w_mag_b_in;
  logic [CNT_W-1:0]  w_step;
  logic [SHW-1:0]    w_shift;
  logic [PW-1:0]     w_pp;
  logic [PW-1:0]     w_sum;

  // Abort outranks a pending operand in IDLE.
  assign w_accept  = (r_state == ST_IDLE) && bus.in_valid && !bus.abort;
  assign w_step_en = (r_state == ST_RUN) && !bus.abort;
  assign w_last    = (r_cnt == CNT_W'(1));

  // Magnitudes are WIDTH-bit unsigned, so the most negative value maps cleanly to 2^(WIDTH-1).
  assign w_mag_a_in = (bus.is_signed && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
  assign w_mag_b_in = (bus.is_signed && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;

  assign w_step  = CNT_W'(STEPS) - r_cnt;
  assign w_shift = SHW'(w_step) * SHW'(BITS_PER_CYCLE);
  assign w_sum   = r_acc + w_pp;

  mult_pp_step #(
    .WIDTH          (WIDTH),
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .SHW            (SHW)
  ) u_pp_step (
    .i_mag_a (r_mag_a),
    .i_digit (r_mag_b[BITS_PER_CYCLE-1:0]),
    .i_shift (w_shift),
    .o_pp    (w_pp)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next = ST_RUN;
      ST_RUN: begin
        if (bus.abort)   w_next = ST_IDLE;
        else if (w_last) w_next = ST_DONE;
      end
      ST_DONE: if (bus.abort || bus.out_ready) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= (w_next == ST_DONE);
      r_busy      <= (w_next != ST_IDLE);
    end
  end

  // Operand capture, accumulation and sign fix-up on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag_a   <= '0;
      r_mag_b   <= '0;
      r_acc     <= '0;
      r_product <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
    end else if (w_accept) begin
      r_sign  <= bus.is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
      r_mag_a <= w_mag_a_in;
      r_mag_b <= w_mag_b_in;
      r_acc   <= '0;
      r_cnt   <= CNT_W'(STEPS);
    end else if (w_step_en) begin
      r_acc   <= w_sum;
      r_mag_b <= r_mag_b >> BITS_PER_CYCLE;
      r_cnt   <= r_cnt - CNT_W'(1);
      if (w_last) r_product <= r_sign ? -w_sum : w_sum;
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.product   = r_product;

endmodule

// File: tb/tb_seq_mult_pipe.sv
// Scoreboarded bench: directed WIDTH=4 scenarios plus randomized WIDTH=8 sweeps at radix 1, 2 and 4.
module tb_seq_mult_pipe;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4_n;
  logic rst8_n;
  int   checks   = 0;
  int   errors   = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: interpret operands per mode, multiply as integers, caller truncates to 2*w bits.
  function automatic longint ref_mul(input longint a, input longint b, input int w, input bit s);
    longint x;
    longint y;
    x = a;
    y = b;
    if (s && a[w-1]) x = a - (longint'(1) << w);
    if (s && b[w-1]) y = b - (longint'(1) << w);
    return x * y;
  endfunction

  function automatic logic [7:0] pick8();
    logic [7:0] corners [6];
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFF};
    if ($urandom_range(0, 4) == 0) return corners[$urandom_range(0, 5)];
    return 8'($urandom);
  endfunction

  // ---------------- WIDTH=4, radix 1: directed scenarios ----------------
  seq_mult_pipe_if #(.WIDTH(4)) if4 ();
  seq_mult_pipe #(.WIDTH(4), .BITS_PER_CYCLE(1)) u_dut4 (.clk(clk), .rst_n(rst4_n), .bus(if4));

  logic [7:0] q4 [$];

  always @(negedge clk) begin
    if (rst4_n && if4.out_valid && if4.out_ready && !if4.abort) begin
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL w4 unexpected result: got 0x%0h expected none", if4.product);
      end else begin
        chk("w4 product", longint'(if4.product), longint'(q4.pop_front()));
      end
    end
  end

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit s, input string name);
    int lat;
    int guard;
    guard = 0;
    while (!if4.in_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    if4.in_valid  = 1'b1;
    if4.op_a      = a;
    if4.op_b      = b;
    if4.is_signed = s;
    @(posedge clk);
    q4.push_back(8'(ref_mul(longint'(a), longint'(b), 4, s)));
    #1;
    if4.in_valid  = 1'b0;
    if4.op_a      = 4'($urandom);
    if4.op_b      = 4'($urandom);
    if4.is_signed = 1'($urandom);
    lat = 0;
    while (!if4.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk({name, " latency"}, longint'(lat), longint'(4));
    if (if4.out_ready) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst4_n        = 1'b0;
    if4.in_valid  = 1'b0;
    if4.is_signed = 1'b0;
    if4.op_a      = '0;
    if4.op_b      = '0;
    if4.abort     = 1'b0;
    if4.out_ready = 1'b1;
    #12;
    chk("reset in_ready",  longint'(if4.in_ready),  longint'(1));
    chk("reset out_valid", longint'(if4.out_valid), longint'(0));
    chk("reset busy",      longint'(if4.busy),      longint'(0));
    chk("reset product",   longint'(if4.product),   longint'(0));
    @(negedge clk) rst4_n = 1'b1;
    @(posedge clk); #1;

    op4(4'd15, 4'd15, 1'b0, "u15x15");
    chk("u15x15 value", longint'(if4.product), longint'(8'hE1));
    op4(4'h8, 4'h7, 1'b1, "s-8x7");
    chk("s-8x7 value", longint'(if4.product), longint'(8'hC8));
    op4(4'h8, 4'h8, 1'b1, "s-8x-8");
    chk("s-8x-8 value", longint'(if4.product), longint'(8'h40));
    op4(4'h5, 4'hD, 1'b1, "s5x-3");
    chk("s5x-3 value", longint'(if4.product), longint'(8'hF1));

    // Backpressure: result must hold while the consumer stalls.
    if4.out_ready = 1'b0;
    op4(4'd6, 4'd7, 1'b0, "bp");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp out_valid", longint'(if4.out_valid), longint'(1));
      chk("bp product",   longint'(if4.product),   longint'(42));
      chk("bp in_ready",  longint'(if4.in_ready),  longint'(0));
    end
    if4.out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release in_ready",  longint'(if4.in_ready),  longint'(1));
    chk("bp release out_valid", longint'(if4.out_valid), longint'(0));

    // Abort while IDLE blocks the accept.
    if4.abort    = 1'b1;
    if4.in_valid = 1'b1;
    if4.op_a     = 4'd1;
    if4.op_b     = 4'd1;
    @(posedge clk); #1;
    if4.abort    = 1'b0;
    if4.in_valid = 1'b0;
    chk("idle abort busy",     longint'(if4.busy),     longint'(0));
    chk("idle abort in_ready", longint'(if4.in_ready), longint'(1));

    // Abort in the second RUN cycle.
    if4.in_valid  = 1'b1;
    if4.op_a      = 4'd9;
    if4.op_b      = 4'd9;
    if4.is_signed = 1'b0;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    chk("abort run busy", longint'(if4.busy), longint'(1));
    @(posedge clk); #1;
    if4.abort = 1'b1;
    @(posedge clk); #1;
    if4.abort = 1'b0;
    chk("abort busy",     longint'(if4.busy),     longint'(0));
    chk("abort in_ready", longint'(if4.in_ready), longint'(1));
    chk("abort product",  longint'(if4.product),  longint'(42));
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      chk("abort no out_valid", longint'(if4.out_valid), longint'(0));
    end
    op4(4'd3, 4'd4, 1'b0, "post-abort");
    chk("post-abort value", longint'(if4.product), longint'(12));

    // Async reset mid-RUN.
    if4.in_valid = 1'b1;
    if4.op_a     = 4'd5;
    if4.op_b     = 4'd5;
    @(posedge clk); #1;
    if4.in_valid = 1'b0;
    @(posedge clk); #1;
    rst4_n = 1'b0;
    #1;
    chk("midrun reset out_valid", longint'(if4.out_valid), longint'(0));
    chk("midrun reset product",   longint'(if4.product),   longint'(0));
    chk("midrun reset busy",      longint'(if4.busy),      longint'(0));
    chk("midrun reset in_ready",  longint'(if4.in_ready),  longint'(1));
    q4.delete();
    @(negedge clk) rst4_n = 1'b1;
    @(posedge clk); #1;
    op4(4'd2, 4'd3, 1'b0, "post-reset");
    chk("post-reset value", longint'(if4.product), longint'(6));
    chk("w4 queue drained", longint'(q4.size()), longint'(0));
    done_cnt++;
  end

  // ---------------- WIDTH=8 randomized sweeps, radix 1/2/4 ----------------
  initial begin
    rst8_n = 1'b0;
    #23 rst8_n = 1'b1;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g8
    localparam int unsigned BPC    = 1 << gi;
    localparam int unsigned STEPS8 = 8 / BPC;

    seq_mult_pipe_if #(.WIDTH(8)) ifc ();
    seq_mult_pipe #(.WIDTH(8), .BITS_PER_CYCLE(BPC)) u_dut (.clk(clk), .rst_n(rst8_n), .bus(ifc));

    logic [15:0] q [$];
    bit          done = 1'b0;

    always @(posedge clk) begin
      #1;
      ifc.out_ready = done ? 1'b1 : ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
      if (rst8_n && ifc.out_valid && ifc.out_ready && !ifc.abort) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL w8 bpc%0d unexpected result: got 0x%0h expected none", BPC, ifc.product);
        end else begin
          chk($sformatf("w8 bpc%0d product", BPC), longint'(ifc.product), longint'(q.pop_front()));
        end
      end
    end

    initial begin : drv
      logic [7:0] a;
      logic [7:0] b;
      bit         s;
      int         lat;
      int         guard;
      ifc.in_valid  = 1'b0;
      ifc.abort     = 1'b0;
      ifc.op_a      = '0;
      ifc.op_b      = '0;
      ifc.is_signed = 1'b0;
      wait (rst8_n === 1'b1);
      @(posedge clk); #1;
      for (int n = 0; n < 1000; n++) begin
        if (n == 0) begin
          a = 8'd200;
          b = 8'd123;
          s = 1'b0;
        end else begin
          a = pick8();
          b = pick8();
          s = 1'($urandom_range(0, 1));
        end
        guard = 0;
        while (!ifc.in_ready && guard < 200) begin @(posedge clk); #1; guard++; end
        if (!ifc.in_ready) begin
          checks++;
          errors++;
          $display("FAIL w8 bpc%0d in_ready stuck: got 0 expected 1", BPC);
          break;
        end
        ifc.in_valid  = 1'b1;
        ifc.op_a      = a;
        ifc.op_b      = b;
        ifc.is_signed = s;
        @(posedge clk);
        q.push_back(16'(ref_mul(longint'(a), longint'(b), 8, s)));
        #1;
        ifc.in_valid  = 1'b0;
        ifc.op_a      = 8'($urandom);
        ifc.op_b      = 8'($urandom);
        ifc.is_signed = 1'($urandom);
        lat = 0;
        while (!ifc.out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        chk($sformatf("w8 bpc%0d latency", BPC), longint'(lat), longint'(STEPS8));
        if (n == 0) chk($sformatf("w8 bpc%0d 200x123", BPC), longint'(ifc.product), longint'(16'h6018));
      end
      guard = 0;
      while (q.size() != 0 && guard < 200) begin @(posedge clk); #1; guard++; end
      chk($sformatf("w8 bpc%0d queue drained", BPC), longint'(q.size()), longint'(0));
      done = 1'b1;
      done_cnt++;
    end
  end

  initial begin
    wait (done_cnt == 4);
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected completion (done_cnt=%0d)", done_cnt);
    $fatal(1, "watchdog expired");
  end

endmodule
